// File: rtl/movsum_pkg.sv
// Shared definitions for the moving-sum filter and its inverter.
// Both ends size their fill counters from fill_w() so they agree on L.
package movsum_pkg;

    localparam int WL_DEF = 32;
    localparam int L_DEF  = 8;

    // Width of a counter that must hold values 0..len inclusive.
    function automatic int fill_w(input int len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/movsum_hist_shift.sv
// L-deep, WL-wide shift register holding the last L reconstructed samples.
// Entry 0 is the newest; entry L-1 (the oldest) is exposed on oldest_o.
module movsum_hist_shift
    import movsum_pkg::*;
#(
    parameter int WL = WL_DEF,
    parameter int L  = L_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [WL-1:0] din_i,
    output logic signed [WL-1:0] oldest_o
);

    logic signed [WL-1:0] hist_q [L];

    // Shift in a new sample on enable; reset and flush zero the whole history.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            hist_q <= '{default: '0};
        end else if (en_i) begin
            hist_q[0] <= din_i;
            for (int i = 1; i < L; i++) begin
                hist_q[i] <= hist_q[i-1];
            end
        end
    end

    assign oldest_o = hist_q[L-1];

endmodule

// File: rtl/moving_sum_inverter.sv
// Inverse of the L-tap moving-sum filter: rebuilds x[n] from the running
// window sum via x[n] = S[n] - S[n-1] + x[n-L], all arithmetic mod 2^WL.
// valid/ready on both sides, one-entry output register, full throughput.
// Optional build macro MOVSUM_INV_PRIME_GATE_EN: suppress the outputs of the
// first L accepts after RST/CLR (for joining a stream mid-flight).
module moving_sum_inverter
    import movsum_pkg::*;
#(
    parameter int WL = WL_DEF,
    parameter int L  = L_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [WL-1:0] sum_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WL-1:0] data_out,
    output logic                 primed
);

    localparam int             FW    = fill_w(L);
    localparam logic [FW-1:0]  L_CNT = FW'(L);

    logic signed [WL-1:0] prev_sum_q, prev_sum_d;
    logic signed [WL-1:0] dout_q, dout_d;
    logic                 ovld_q, ovld_d;
    logic [FW-1:0]        fill_q, fill_d;

    logic signed [WL-1:0] hist_oldest;
    logic signed [WL-1:0] x_rec;
    logic                 accept;
    logic                 emit;

    // New samples are taken only when the output slot is free or draining now.
    assign in_ready = !RST && !CLR && (!ovld_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign primed   = (fill_q == L_CNT);
    assign x_rec    = sum_in - prev_sum_q + hist_oldest;

`ifdef MOVSUM_INV_PRIME_GATE_EN
    // Until the history is full the reconstruction is not trustworthy.
    assign emit = accept && primed;
`else
    assign emit = accept;
`endif

    movsum_hist_shift #(
        .WL (WL),
        .L  (L)
    ) u_hist (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (CLR),
        .en_i     (accept),
        .din_i    (x_rec),
        .oldest_o (hist_oldest)
    );

    // Next-state for history sum, fill counter and the output register.
    always_comb begin
        prev_sum_d = prev_sum_q;
        fill_d     = fill_q;
        dout_d     = dout_q;
        ovld_d     = ovld_q;
        if (ovld_q && out_ready) begin
            ovld_d = 1'b0;
        end
        if (CLR) begin
            prev_sum_d = '0;
            fill_d     = '0;
        end else if (accept) begin
            prev_sum_d = sum_in;
            if (fill_q != L_CNT) begin
                fill_d = fill_q + 1'b1;
            end
            if (emit) begin
                dout_d = x_rec;
                ovld_d = 1'b1;
            end
        end
    end

    // State registers; reset drops everything including a pending output.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_sum_q <= '0;
            fill_q     <= '0;
            dout_q     <= '0;
            ovld_q     <= 1'b0;
        end else begin
            prev_sum_q <= prev_sum_d;
            fill_q     <= fill_d;
            dout_q     <= dout_d;
            ovld_q     <= ovld_d;
        end
    end

    assign data_out  = dout_q;
    assign out_valid = ovld_q;

endmodule

// File: tb/tb_moving_sum_inverter.sv
// Bench for moving_sum_inverter (WL=16, L=4). A forward moving-sum model
// turns chosen samples into sums; the samples themselves are the expected
// outputs, queued on accept and compared when the DUT pops an output.
module tb_moving_sum_inverter;

    localparam int WL = 16;
    localparam int L  = 4;

    logic          CLK = 1'b0;
    logic          RST, CLR, in_valid, in_ready, out_valid, out_ready, primed;
    logic [WL-1:0] sum_in, data_out;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    logic [WL-1:0] exp_q [$];
    logic [WL-1:0] fwd_hist [L];
    logic [WL-1:0] fwd_sum;
    int            fwd_fill;

    always #5 CLK = ~CLK;

    moving_sum_inverter #(.WL(WL), .L(L)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CLR       (CLR),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .primed    (primed)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fwd_sum  = '0;
        fwd_fill = 0;
        for (int i = 0; i < L; i++) fwd_hist[i] = '0;
    endtask

    // Drive one sample through the forward model; returns once accepted.
    task automatic send(input logic [WL-1:0] x);
        logic [WL-1:0] s;
        bit            ok;
        s        = fwd_sum + x - fwd_hist[L-1];
        in_valid = 1'b1;
        sum_in   = s;
        ok       = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge CLK);
            ok = in_ready;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            check("accept_timeout", 16'(0), 16'(1));
        end else begin
            for (int i = L - 1; i > 0; i--) fwd_hist[i] = fwd_hist[i-1];
            fwd_hist[0] = x;
            fwd_sum     = s;
`ifdef MOVSUM_INV_PRIME_GATE_EN
            if (fwd_fill >= L) exp_q.push_back(x);
`else
            exp_q.push_back(x);
`endif
            fwd_fill++;
        end
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every output pop must match the oldest queued sample.
    always @(negedge CLK) begin
        if (!RST && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", data_out, 16'hDEAD);
            end else begin
                check("sb_data", data_out, exp_q.pop_front());
                pops++;
            end
        end
    end

    initial begin
        int p0;
        RST = 1'b1; CLR = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sum_in = '0;
        model_reset();
        @(negedge CLK);
        check("rst_in_ready", 16'(in_ready), 16'(0));
        idle(2);
        RST = 1'b0;
        #1;
        check("rst_out_valid", 16'(out_valid), 16'(0));
        check("rst_primed", 16'(primed), 16'(0));
        check("rst_data", data_out, 16'(0));
        check("rst_release_ready", 16'(in_ready), 16'(1));

        // Ramp 1..6: one-cycle latency, primed after the 4th accept.
        out_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            send(16'(i));
`ifdef MOVSUM_INV_PRIME_GATE_EN
            if (i <= L) check("t6_gated", 16'(out_valid), 16'(0));
            else        check("t6_data", data_out, 16'(i));
`else
            check("t1_lat_vld", 16'(out_valid), 16'(1));
            check("t1_lat_data", data_out, 16'(i));
`endif
            check("t1_primed", 16'(primed), 16'(i >= L));
        end
        idle(3);

`ifndef MOVSUM_INV_PRIME_GATE_EN
        // Backpressure: first output stalls, input must wait, nothing lost.
        do_clr();
        out_ready = 1'b0;
        send(16'd1);
        in_valid = 1'b1;
        sum_in   = fwd_sum + 16'd2 - fwd_hist[L-1];
        repeat (3) begin
            @(negedge CLK);
            check("t2_stall_ready", 16'(in_ready), 16'(0));
            check("t2_hold_data", data_out, 16'd1);
        end
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        p0 = pops;
        send(16'd2);
        send(16'd3);
        send(16'd4);
        idle(3);
        check("t2_pop_count", 16'(pops - p0), 16'(4));
`endif

        // Wrap-around: sums overflow yet samples are exact.
        do_clr();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(16'h7FFF);
`ifndef MOVSUM_INV_PRIME_GATE_EN
            check("t3_wrap_data", data_out, 16'h7FFF);
`endif
        end
        send(16'hFFFF);
        check("t3_neg_data", data_out, 16'hFFFF);
        idle(3);

        // CLR with a pending output: pending drains, history restarts.
        do_clr();
        out_ready = 1'b1;
        send(16'd1);
        send(16'd2);
        send(16'd3);
        out_ready = 1'b0;
        CLR = 1'b1;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        model_reset();
`ifndef MOVSUM_INV_PRIME_GATE_EN
        check("t4_pend_vld", 16'(out_valid), 16'(1));
        check("t4_pend_data", data_out, 16'd3);
`endif
        out_ready = 1'b1;
        send(16'd5);
`ifndef MOVSUM_INV_PRIME_GATE_EN
        check("t4_after_clr", data_out, 16'd5);
`endif
        check("t4_primed", 16'(primed), 16'(0));
        idle(3);

        // RST mid-stream with input offered and output pending.
        do_clr();
        out_ready = 1'b0;
        send(16'd7);
        in_valid = 1'b1;
        sum_in   = 16'd123;
        RST      = 1'b1;
        @(negedge CLK);
        check("t5_rst_ready", 16'(in_ready), 16'(0));
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        model_reset();
        check("t5_out_valid", 16'(out_valid), 16'(0));
        check("t5_primed", 16'(primed), 16'(0));
        check("t5_data", data_out, 16'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom_range(0, 16'hFFFF)));
        end
        idle(4);
        check("sb_empty", 16'(exp_q.size()), 16'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
